multicycle_control: RTL and testbench

- Main control FSM for the multicycle MIPS datapath: one shared 32-bit ALU, one shared memory port, an instruction register, and the PC/register-file muxes.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives all mux selects, write strobes and the 3-bit ALU control, and stalls on a memory-ready handshake.
- Sits beside the datapath in the CPU top level.

---
 rtl/mips_ctrl_pkg.sv | 50 +++++
 rtl/multicycle_control_if.sv | 36 +++
 rtl/alu_decoder.sv | 24 ++
 rtl/multicycle_control.sv | 157 +++++++++++++++
 tb/tb_multicycle_control.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcode/funct
// values, ALU control codes and the datapath mux select codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB,
        IEX, IWB, BRANCH, JUMP, JAL, ILLEGAL
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // bit2 inverts B, [1:0] picks SLT/SUM/OR/AND
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle FSM (master) and the datapath (slave):
// IR fields and memory handshake in, mux selects and write strobes out.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       branch_eq;
    logic       branch_ne;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_control;
    logic       illegal;

    modport master (
        input  opcode, funct, mem_ready,
        output mem_read, mem_write, i_or_d, ir_write, pc_write, branch_eq, branch_ne,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src,
               alu_control, illegal
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  mem_read, mem_write, i_or_d, ir_write, pc_write, branch_eq, branch_ne,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src,
               alu_control, illegal
    );
endinterface

// File: rtl/alu_decoder.sv
// R-type funct field to ALU control; funct_valid flags the supported subset.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_valid
);

    always_comb begin
        // NOTE: every output gets a default before the case, so no path infers a latch.
        alu_control = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS: sequences fetch/decode/execute/memory/
// writeback, drives the datapath controls and counts retired instructions.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus,
    output logic [CNT_W-1:0]     instr_count
);

    state_t     state, next_state;
    logic [2:0] funct_alu;
    logic       funct_valid;
    logic       retire;

    alu_decoder u_alu_decoder (
        .funct       (bus.funct),
        .alu_control (funct_alu),
        .funct_valid (funct_valid)
    );

    // ILLEGAL returns to FETCH without retiring; a stalled FETCH is not a transition
    assign retire = (next_state == FETCH) && (state != FETCH) && (state != ILLEGAL);

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (reset) begin
            state       <= FETCH;
            instr_count <= '0;
        end else begin
            state <= next_state;
            if (retire) instr_count <= instr_count + 1'b1;
        end
    end

    always_comb begin
        next_state      = state;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.i_or_d      = 1'b0;
        bus.ir_write    = 1'b0;
        bus.pc_write    = 1'b0;
        bus.branch_eq   = 1'b0;
        bus.branch_ne   = 1'b0;
        bus.reg_write   = 1'b0;
        bus.reg_dst     = REGDST_RT;
        bus.mem_to_reg  = WB_ALUOUT;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = SRCB_B;
        bus.pc_src      = PCSRC_ALU;
        bus.alu_control = 3'b000;
        bus.illegal     = 1'b0;
        // reset silences every strobe, so an abandoned instruction writes nothing
        if (!reset) begin
            case (state)
                FETCH: begin
                    bus.mem_read    = 1'b1;
                    bus.alu_src_b   = SRCB_FOUR;
                    bus.alu_control = ALU_ADD;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        next_state   = DECODE;
                    end
                end
                DECODE: begin
                    bus.alu_src_b   = SRCB_IMMSH;
                    bus.alu_control = ALU_ADD;
                    case (bus.opcode)
                        OP_LW, OP_SW:     next_state = MEMADR;
                        OP_RTYPE:         next_state = funct_valid ? REX : ILLEGAL;
                        OP_BEQ, OP_BNE:   next_state = BRANCH;
                        OP_ADDI, OP_SLTI: next_state = IEX;
                        OP_J:             next_state = JUMP;
                        OP_JAL:           next_state = JAL;
                        default:          next_state = ILLEGAL;
                    endcase
                end
                MEMADR: begin
                    bus.alu_src_a   = 1'b1;
                    bus.alu_src_b   = SRCB_IMM;
                    bus.alu_control = ALU_ADD;
                    next_state      = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
                end
                MEMRD: begin
                    bus.mem_read = 1'b1;
                    bus.i_or_d   = 1'b1;
                    if (bus.mem_ready) next_state = MEMWB;
                end
                MEMWB: begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = REGDST_RT;
                    bus.mem_to_reg = WB_MDR;
                    next_state     = FETCH;
                end
                MEMWR: begin
                    bus.mem_write = 1'b1;
                    bus.i_or_d    = 1'b1;
                    if (bus.mem_ready) next_state = FETCH;
                end
                REX: begin
                    bus.alu_src_a   = 1'b1;
                    bus.alu_src_b   = SRCB_B;
                    bus.alu_control = funct_alu;
                    next_state      = RWB;
                end
                RWB: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = REGDST_RD;
                    next_state    = FETCH;
                end
                IEX: begin
                    bus.alu_src_a   = 1'b1;
                    bus.alu_src_b   = SRCB_IMM;
                    bus.alu_control = (bus.opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                    next_state      = IWB;
                end
                IWB: begin
                    bus.reg_write = 1'b1;
                    next_state    = FETCH;
                end
                BRANCH: begin
                    bus.alu_src_a   = 1'b1;
                    bus.alu_src_b   = SRCB_B;
                    bus.alu_control = ALU_SUB;
                    bus.pc_src      = PCSRC_ALUOUT;
                    bus.branch_eq   = (bus.opcode == OP_BEQ);
                    bus.branch_ne   = (bus.opcode == OP_BNE);
                    next_state      = FETCH;
                end
                JUMP: begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = PCSRC_JUMP;
                    next_state   = FETCH;
                end
                JAL: begin
                    // PC already holds PC+4 from FETCH, which is the link value
                    bus.pc_write   = 1'b1;
                    bus.pc_src     = PCSRC_JUMP;
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = REGDST_RA;
                    bus.mem_to_reg = WB_PC;
                    next_state     = FETCH;
                end
                ILLEGAL: begin
                    bus.illegal = 1'b1;
                    next_state  = FETCH;
                end
                default: next_state = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-instruction expected output sequences
// checked every cycle, plus literal spot checks and a narrow-counter wrap instance.
module tb_multicycle_control;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       branch_eq;
        logic       branch_ne;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_control;
        logic       illegal;
    } ctrl_t;

    logic        clk;
    logic        reset;
    logic [31:0] cnt32;
    logic [2:0]  cnt3;

    multicycle_control_if bus ();
    multicycle_control_if bus3 ();

    multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .bus(bus), .instr_count(cnt32)
    );
    multicycle_control #(.CNT_W(3)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3), .instr_count(cnt3)
    );

    assign bus3.opcode    = bus.opcode;
    assign bus3.funct     = bus.funct;
    assign bus3.mem_ready = bus.mem_ready;

    ctrl_t obs, obs3;
    assign obs  = {bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write, bus.pc_write,
                   bus.branch_eq, bus.branch_ne, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                   bus.alu_src_a, bus.alu_src_b, bus.pc_src, bus.alu_control, bus.illegal};
    assign obs3 = {bus3.mem_read, bus3.mem_write, bus3.i_or_d, bus3.ir_write, bus3.pc_write,
                   bus3.branch_eq, bus3.branch_ne, bus3.reg_write, bus3.reg_dst, bus3.mem_to_reg,
                   bus3.alu_src_a, bus3.alu_src_b, bus3.pc_src, bus3.alu_control, bus3.illegal};

    int          vectors = 0;
    int          miscompares = 0;
    ctrl_t       exp_c;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_cnt = 32'd0;
    logic        junk = 1'b0;
    ctrl_t       hist[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_valid) begin
            check("ctrl", obs, exp_c);
            check("ctrl_w3", obs3, exp_c);
            check("instr_count", cnt32, exp_cnt);
            check("instr_count_w3", {29'd0, cnt3}, {29'd0, exp_cnt[2:0]});
            hist.push_back(obs);
        end
    end

    // one clock: apply inputs and the expectation, then step past the rising edge
    task automatic cyc(input ctrl_t e, input logic rdy, input logic rst);
        reset         = rst;
        bus.mem_ready = rdy;
        exp_c         = e;
        exp_valid     = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic ctrl_t c_fetch(input logic rdy);
        ctrl_t c = '0;
        c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_control = 3'b001;
        c.ir_write = rdy;  c.pc_write = rdy;
        return c;
    endfunction

    function automatic ctrl_t c_exec(input logic [1:0] srcb, input logic [2:0] alu);
        ctrl_t c = '0;
        c.alu_src_a = 1'b1; c.alu_src_b = srcb; c.alu_control = alu;
        return c;
    endfunction

    function automatic ctrl_t c_wb(input logic [1:0] dst, input logic [1:0] m2r);
        ctrl_t c = '0;
        c.reg_write = 1'b1; c.reg_dst = dst; c.mem_to_reg = m2r;
        return c;
    endfunction

    // returns {valid, alu_control} for an R-type funct
    function automatic logic [3:0] rtype_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b1_001;
            6'b100010: return 4'b1_101;
            6'b100100: return 4'b1_011;
            6'b100101: return 4'b1_010;
            6'b101010: return 4'b1_100;
            default:   return 4'b0_000;
        endcase
    endfunction

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fwait, input int mwait);
        ctrl_t      c;
        logic [3:0] ra;
        logic       retires = 1'b1;
        bus.opcode = op;
        bus.funct  = fn;
        hist.delete();
        for (int i = 0; i < fwait; i++) cyc(c_fetch(1'b0), 1'b0, 1'b0);
        cyc(c_fetch(1'b1), 1'b1, 1'b0);
        c = '0; c.alu_src_b = 2'b11; c.alu_control = 3'b001;
        junk = ~junk;
        cyc(c, junk, 1'b0);
        ra = rtype_alu(fn);
        if ((op == 6'b000000 && !ra[3]) ||
            !(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                         6'b001000, 6'b001010, 6'b000010, 6'b000011})) begin
            c = '0; c.illegal = 1'b1;
            cyc(c, junk, 1'b0);
            retires = 1'b0;
        end else if (op == 6'b100011 || op == 6'b101011) begin
            cyc(c_exec(2'b10, 3'b001), ~junk, 1'b0);
            c = '0; c.i_or_d = 1'b1;
            if (op == 6'b100011) c.mem_read = 1'b1; else c.mem_write = 1'b1;
            for (int i = 0; i < mwait; i++) cyc(c, 1'b0, 1'b0);
            cyc(c, 1'b1, 1'b0);
            if (op == 6'b100011) cyc(c_wb(2'b00, 2'b01), junk, 1'b0);
        end else if (op == 6'b000000) begin
            cyc(c_exec(2'b00, ra[2:0]), junk, 1'b0);
            cyc(c_wb(2'b01, 2'b00), ~junk, 1'b0);
        end else if (op == 6'b000100 || op == 6'b000101) begin
            c = c_exec(2'b00, 3'b101);
            c.pc_src = 2'b01;
            c.branch_eq = (op == 6'b000100);
            c.branch_ne = (op == 6'b000101);
            cyc(c, junk, 1'b0);
        end else if (op == 6'b001000 || op == 6'b001010) begin
            cyc(c_exec(2'b10, (op == 6'b001010) ? 3'b100 : 3'b001), junk, 1'b0);
            cyc(c_wb(2'b00, 2'b00), ~junk, 1'b0);
        end else begin
            c = (op == 6'b000011) ? c_wb(2'b10, 2'b10) : ctrl_t'('0);
            c.pc_write = 1'b1; c.pc_src = 2'b10;
            cyc(c, junk, 1'b0);
        end
        if (retires) exp_cnt = exp_cnt + 32'd1;
    endtask

    initial begin
        int wcount;
        ctrl_t c;
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        bus.opcode = 6'd0;
        bus.funct = 6'd0;
        #1;
        cyc('0, 1'b1, 1'b1);
        cyc('0, 1'b1, 1'b1);

        run_instr(6'b100011, 6'd0, 0, 0);                       // lw
        check("first_fetch_mem_read", {31'd0, hist[0].mem_read}, 32'd1);
        check("lw_memwb", {27'd0, hist[4].reg_write, hist[4].mem_to_reg, hist[4].reg_dst}, 32'b1_01_00);
        check("lw_count", cnt32, 32'd1);

        run_instr(6'b000000, 6'b100010, 0, 0);                  // sub
        check("sub_rex_alu", {29'd0, hist[2].alu_control}, 32'b101);
        check("sub_rwb", {29'd0, hist[3].reg_write, hist[3].reg_dst}, 32'b1_01);
        run_instr(6'b000000, 6'b100000, 1, 0);                  // add
        run_instr(6'b000000, 6'b100100, 0, 0);                  // and
        run_instr(6'b000000, 6'b100101, 0, 0);                  // or
        run_instr(6'b000000, 6'b101010, 0, 0);                  // slt
        run_instr(6'b001000, 6'b111111, 0, 0);                  // addi
        run_instr(6'b001010, 6'd0, 0, 0);                       // slti
        run_instr(6'b000101, 6'd0, 0, 0);                       // bne
        run_instr(6'b000100, 6'd0, 0, 0);                       // beq
        check("beq_branch", {26'd0, hist[2].branch_eq, hist[2].pc_src, hist[2].alu_control}, 32'b1_01_101);

        run_instr(6'b101011, 6'd0, 2, 3);                       // sw with stalls
        wcount = 0;
        foreach (hist[i]) if (hist[i].mem_write) wcount++;
        check("sw_mem_write_cycles", wcount, 32'd4);
        check("sw_count", cnt32, 32'd11);

        run_instr(6'b000011, 6'd0, 0, 0);                       // jal
        check("jal_ctrl", {24'd0, hist[2].pc_write, hist[2].pc_src, hist[2].reg_write,
                           hist[2].reg_dst, hist[2].mem_to_reg}, 32'b1_10_1_10_10);

        run_instr(6'b111111, 6'd0, 0, 0);                       // bad opcode
        check("illegal_op_pulse", {31'd0, hist[2].illegal}, 32'd1);
        run_instr(6'b000000, 6'b000111, 0, 0);                  // bad funct
        wcount = 0;
        foreach (hist[i]) if (hist[i].illegal) wcount++;
        check("illegal_fn_one_cycle", wcount, 32'd1);
        check("illegal_no_count", cnt32, 32'd12);

        // lw abandoned by reset while stalled in MEMRD
        bus.opcode = 6'b100011;
        cyc(c_fetch(1'b1), 1'b1, 1'b0);
        c = '0; c.alu_src_b = 2'b11; c.alu_control = 3'b001;
        cyc(c, 1'b0, 1'b0);
        cyc(c_exec(2'b10, 3'b001), 1'b0, 1'b0);
        c = '0; c.mem_read = 1'b1; c.i_or_d = 1'b1;
        cyc(c, 1'b0, 1'b0);
        cyc('0, 1'b1, 1'b1);
        exp_cnt = 32'd0;
        run_instr(6'b000010, 6'd0, 0, 0);                       // j
        check("post_reset_fetch", {30'd0, hist[0].mem_read, hist[0].reg_write}, 32'b10);

        for (int i = 0; i < 6; i++) run_instr(6'b000010, 6'd0, 0, 0);
        check("w3_all_ones", {29'd0, cnt3}, 32'd7);
        run_instr(6'b000011, 6'd0, 0, 0);
        check("w3_wrap", {29'd0, cnt3}, 32'd0);
        check("w32_after_wrap", cnt32, 32'd8);

        exp_valid = 1'b0;
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
